// File: rtl/mobo_arbiter_pkg.sv
// Shared arbiter state encodings and port indices.
package mobo_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_VGA = 1'b1;

   function automatic logic onehot_to_port(input logic [1:0] oh);
      return oh[1] ? PORT_VGA : PORT_CPU;
   endfunction

endpackage

// File: rtl/mobo_arbiter_rr_pick.sv
// Two-way round-robin winner select: the port not served last wins a tie.
// Latency: combinational.
// Backpressure: none; pick is all-zero when no request is present.
module rr_pick
   import mobo_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick
);

   always_comb begin
      pick = req;
      if (req == 2'b11) begin
         pick = (last == PORT_VGA) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mobo_arbiter.sv
// Two-port memory arbiter (CPU, VGA writer); MOBO_ARB_TIMEOUT_EN adds an ISSUE timeout with err.
// Latency: req sampled -> ack is 3 cycles minimum, plus one cycle per mem_ready wait state.
// Backpressure: ISSUE holds the memory bus until mem_ready; losing requests are held pending.
module mobo_arbiter
   import mobo_arbiter_pkg::*;
#(
   parameter int word_width     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [word_width-1:0] addr0,
   input  logic [word_width-1:0] addr1,
   input  logic [word_width-1:0] wdata0,
   input  logic [word_width-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [word_width-1:0] rdata0,
   output logic [word_width-1:0] rdata1,
   output logic                  err,
   output logic [1:0]            grant,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [word_width-1:0] mem_addr,
   output logic [word_width-1:0] mem_wdata,
   input  logic [word_width-1:0] mem_rdata,
   input  logic                  mem_ready
);

   arb_state_t            state;
   logic                  last;
   logic                  owner;
   logic [1:0]            pend;
   logic [1:0]            req_eff;
   logic [1:0]            pick;
   logic [word_width-1:0] rd_val;

   // A losing requester stays pending even if it drops req before the next IDLE.
   assign req_eff = {req1, req0} | pend;
   assign rd_val  = mem_we ? '0 : mem_rdata;
   assign owner   = onehot_to_port(grant);

   rr_pick u_rr_pick (
      .req  (req_eff),
      .last (last),
      .pick (pick)
   );

`ifdef MOBO_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CW-1:0] tmo_cnt;
   logic          tmo_hit;
   assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ARB_IDLE;
         last      <= PORT_VGA;
         pend      <= 2'b00;
         grant     <= 2'b00;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         err       <= 1'b0;
`ifdef MOBO_ARB_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         case (state)
            ARB_IDLE: begin
               if (|req_eff) begin
                  grant     <= pick;
                  pend      <= req_eff & ~pick;
                  mem_en    <= 1'b1;
                  mem_we    <= pick[1] ? we1    : we0;
                  mem_addr  <= pick[1] ? addr1  : addr0;
                  mem_wdata <= pick[1] ? wdata1 : wdata0;
`ifdef MOBO_ARB_TIMEOUT_EN
                  tmo_cnt   <= '0;
`endif
                  state     <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               pend <= pend | ({req1, req0} & ~grant);
               if (mem_ready) begin
                  mem_en <= 1'b0;
                  ack0   <= ~owner;
                  ack1   <= owner;
                  rdata0 <= owner ? '0 : rd_val;
                  rdata1 <= owner ? rd_val : '0;
                  state  <= ARB_RESP;
               end
`ifdef MOBO_ARB_TIMEOUT_EN
               else if (tmo_hit) begin
                  mem_en <= 1'b0;
                  ack0   <= ~owner;
                  ack1   <= owner;
                  rdata0 <= '0;
                  rdata1 <= '0;
                  err    <= 1'b1;
                  state  <= ARB_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            ARB_RESP: begin
               pend      <= pend | ({req1, req0} & ~grant);
               last      <= owner;
               grant     <= 2'b00;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               ack0      <= 1'b0;
               ack1      <= 1'b0;
               rdata0    <= '0;
               rdata1    <= '0;
               err       <= 1'b0;
               state     <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mobo_arbiter.sv
// Scoreboard bench for mobo_arbiter: directed transactions, monitor checks every ack.
module tb_mobo_arbiter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [W-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic         ack0, ack1, err, mem_en, mem_we;
   logic [W-1:0] rdata0, rdata1, mem_addr, mem_wdata;
   logic [1:0]   grant;
   logic [W-1:0] mem_rdata = '0;
   logic         mem_ready = 1'b0;

   always #5 clk = ~clk;

   mobo_arbiter #(.word_width(W), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .err(err),
      .grant(grant), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   typedef struct {
      logic         port;
      logic [W-1:0] rdata;
      logic         err;
   } exp_t;

   exp_t         sb[$];
   exp_t         e;
   int           tests = 0;
   int           fails = 0;
   int           ready_wait = 0;
   int           wcnt = 0;
   logic [W-1:0] rd_val = '0;
   logic         prev_ack = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_ack(input logic port, input logic [W-1:0] rdata, input logic err_exp);
      exp_t x;
      x.port  = port;
      x.rdata = rdata;
      x.err   = err_exp;
      sb.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic port, input int limit, output int n);
      n = 0;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (port ? ack1 : ack0) begin
            n = i;
            if (port) req1 = 1'b0;
            else      req0 = 1'b0;
            break;
         end
      end
      if (n == 0) begin
         tests++;
         fails++;
         $display("FAIL ack_timeout: port %0d gave no ack within %0d cycles", port, limit);
      end
   endtask

   // Memory responder: raises mem_ready after ready_wait ISSUE cycles.
   always @(negedge clk) begin
      if (mem_en) begin
         mem_ready = (wcnt == ready_wait);
         mem_rdata = rd_val;
         wcnt      = wcnt + 1;
      end else begin
         mem_ready = 1'b0;
         mem_rdata = 32'hBAD0_BAD0;
         wcnt      = 0;
      end
   end

   // Monitor: every ack pops one expected completion.
   always @(negedge clk) begin
      if (ack0 || ack1) begin
         check("ack_both_high", ack0 & ack1, 0);
         check("ack_pulse_width", prev_ack, 0);
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack: ack0=%0b ack1=%0b expected none", ack0, ack1);
         end else begin
            e = sb.pop_front();
            check("ack_port", ack1, e.port);
            check("ack_rdata", ack1 ? rdata1 : rdata0, e.rdata);
            check("ack_err", err, e.err);
         end
      end
      prev_ack = ack0 | ack1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int en_cnt, ack_cnt, ack0_cnt, bad;

      // Reset state
      tick();
      tick();
      @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
      check("rst_acks", {ack0, ack1, err}, 0);
      check("rst_rdata", {rdata0, rdata1}, 0);
      rst = 1'b1;
      tick();

      // Single read, mem_ready on first ISSUE cycle
      rd_val = 32'hDEAD_BEEF; ready_wait = 0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      expect_ack(1'b0, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      check("rd_idle_mem_en", mem_en, 0);
      @(negedge clk);
      check("rd_issue_grant", grant, 2'b01);
      check("rd_issue_mem_en", mem_en, 1);
      check("rd_issue_addr", mem_addr, 32'h10);
      check("rd_issue_we", mem_we, 0);
      @(negedge clk);
      check("rd_ack0_cycle3", ack0, 1);
      check("rd_ack1_low", ack1, 0);
      req0 = 1'b0;
      tick();

      // Tie after reset: port 0, then port 1, then port 0 again
      rst = 1'b0;
      tick();
      rst = 1'b1;
      rd_val = 32'h1111_2222;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'h77;
      expect_ack(1'b0, 32'h1111_2222, 1'b0);
      expect_ack(1'b1, 32'h0, 1'b0);
      wait_ack(1'b0, 20, n);
      check("tie1_port0_latency", n, 3);
      wait_ack(1'b1, 20, n);
      check("tie1_port1_latency", n, 3);
      tick();
      rd_val = 32'h3333_4444;
      req0 = 1'b1; req1 = 1'b1;
      expect_ack(1'b0, 32'h3333_4444, 1'b0);
      expect_ack(1'b1, 32'h0, 1'b0);
      wait_ack(1'b0, 20, n);
      check("tie2_port0_first", n, 3);
      wait_ack(1'b1, 20, n);
      check("tie2_port1_second", n, 3);
      tick();

      // Wait states: write from port 1, mem_ready after 5 extra cycles
      ready_wait = 5; rd_val = 32'hCAFE_F00D;
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h200; wdata1 = 32'h55;
      expect_ack(1'b1, 32'h0, 1'b0);
      en_cnt = 0; ack_cnt = 0; ack0_cnt = 0; bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_en) begin
            en_cnt++;
            if (mem_addr !== 32'h200 || mem_wdata !== 32'h55 || mem_we !== 1'b1 || grant !== 2'b10)
               bad++;
         end
         if (ack1) begin
            ack_cnt++;
            req1 = 1'b0;
         end
         if (ack0) ack0_cnt++;
      end
      check("ws_mem_en_cycles", en_cnt, 6);
      check("ws_bus_stable", bad, 0);
      check("ws_ack1_count", ack_cnt, 1);
      check("ws_ack0_count", ack0_cnt, 0);
      tick();

      // Reset in the middle of an ISSUE wait
      ready_wait = 1000;
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h44; wdata0 = 32'h99;
      repeat (3) @(negedge clk);
      check("mid_mem_en_before", mem_en, 1);
      tick();
      rst = 1'b0; req0 = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_grant", grant, 0);
      check("mid_rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
      check("mid_rst_outs", {ack0, ack1, err}, 0);
      ack_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack0 || ack1) ack_cnt++;
      end
      check("mid_rst_no_ack", ack_cnt, 0);
      tick();
      ready_wait = 0; rd_val = 32'h0000_5A5A;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
      expect_ack(1'b1, 32'h0000_5A5A, 1'b0);
      wait_ack(1'b1, 20, n);
      check("post_rst_latency", n, 3);
      tick();

      // Request from the other port during a transaction wins next
      ready_wait = 2; rd_val = 32'h0101_0101;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h60;
      expect_ack(1'b0, 32'h0101_0101, 1'b0);
      repeat (2) @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h64;
      expect_ack(1'b1, 32'h0101_0101, 1'b0);
      wait_ack(1'b0, 20, n);
      check("pend_first_ack", n, 3);
      req0 = 1'b1; addr0 = 32'h68;
      expect_ack(1'b0, 32'h0101_0101, 1'b0);
      wait_ack(1'b1, 20, n);
      check("pend_port1_next", n, 5);
      wait_ack(1'b0, 20, n);
      check("pend_port0_last", n, 5);
      tick();

      // mem_ready never arrives
      ready_wait = 1000;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h70;
`ifdef MOBO_ARB_TIMEOUT_EN
      expect_ack(1'b0, 32'h0, 1'b1);
      wait_ack(1'b0, 20, n);
      check("tmo_ack_latency", n, 6);
      tick();
`else
      en_cnt = 0;
      for (int i = 0; i < 110; i++) begin
         @(negedge clk);
         if (mem_en) en_cnt++;
      end
      check("no_tmo_mem_en_held", en_cnt, 109);
      check("no_tmo_err", err, 0);
      tick();
      req0 = 1'b0; rst = 1'b0;
      tick();
      rst = 1'b1;
`endif

      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
